// File: rtl/egg_timer_core.sv
// Egg-timer controller: key sync/edge detect, tick prescaler, MM:SS countdown FSM.
// Optional EGG_TIMER_RELOAD_EN: FINISHED + key0 reloads the last set time into STOPPED.
module egg_timer_core #(
   parameter int TICK_DIV = 50_000_000,
   parameter int MAX_MIN  = 99,
   localparam int MIN_W   = $clog2(MAX_MIN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       keyin,
   input  logic [7:0]       setval,
   output logic [2:0]       state_o,
   output logic [MIN_W-1:0] min_o,
   output logic [5:0]       sec_o,
   output logic             done_o,
   output logic             blink_o
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [2:0] S_SET_SEC  = 3'b000;
   localparam logic [2:0] S_SET_MIN  = 3'b001;
   localparam logic [2:0] S_STOPPED  = 3'b010;
   localparam logic [2:0] S_RUNNING  = 3'b011;
   localparam logic [2:0] S_FINISHED = 3'b100;
   localparam logic [2:0] S_IDLE     = 3'b101;

   logic [1:0]       s1, s2, s3;
   logic             press0, press1;
   logic [2:0]       state, state_nxt;
   logic [CW-1:0]    pcnt;
   logic             cnt_en, tick, zero, blink;
   logic [MIN_W-1:0] min_q, min_clamp;
   logic [5:0]       sec_q, sec_clamp;
`ifdef EGG_TIMER_RELOAD_EN
   logic [MIN_W-1:0] reload_min;
   logic [5:0]       reload_sec;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 2'b11;
         s2 <= 2'b11;
         s3 <= 2'b11;
      end else begin
         s1 <= keyin;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Keys are active-low: an event is the falling edge seen on the synchronised copy.
   assign press0 = s3[0] & ~s2[0];
   assign press1 = s3[1] & ~s2[1];

   assign cnt_en    = (state == S_RUNNING) || (state == S_FINISHED);
   assign tick      = cnt_en && (pcnt == CW'(TICK_DIV - 1));
   assign zero      = (min_q == '0) && (sec_q == '0);
   assign sec_clamp = (setval > 8'd59) ? 6'd59 : setval[5:0];
   assign min_clamp = (setval > 8'(MAX_MIN)) ? MIN_W'(MAX_MIN) : setval[MIN_W-1:0];

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (press0) state_nxt = S_SET_SEC;
         S_SET_SEC: if (press0) state_nxt = S_SET_MIN;
         S_SET_MIN: if (press0) state_nxt = S_STOPPED;
         S_STOPPED: begin
            if (press1)      state_nxt = zero ? S_FINISHED : S_RUNNING;
            else if (press0) state_nxt = S_SET_SEC;
         end
         S_RUNNING: begin
            if (press1)                                       state_nxt = S_STOPPED;
            else if (tick && min_q == '0 && sec_q == 6'd1)    state_nxt = S_FINISHED;
         end
         S_FINISHED: begin
`ifdef EGG_TIMER_RELOAD_EN
            if (press0) state_nxt = S_STOPPED;
`else
            if (press0) state_nxt = S_SET_SEC;
`endif
         end
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         pcnt  <= '0;
         blink <= 1'b0;
         min_q <= '0;
         sec_q <= '0;
`ifdef EGG_TIMER_RELOAD_EN
         reload_min <= '0;
         reload_sec <= '0;
`endif
      end else begin
         state <= state_nxt;
         // Any state change restarts the full tick interval.
         if (!cnt_en || (state_nxt != state) || tick) pcnt <= '0;
         else                                         pcnt <= pcnt + 1'b1;
         blink <= (state == S_FINISHED && state_nxt == S_FINISHED) ? (blink ^ tick) : 1'b0;
         case (state)
            S_SET_SEC: sec_q <= sec_clamp;
            S_SET_MIN: begin
               min_q <= min_clamp;
`ifdef EGG_TIMER_RELOAD_EN
               if (press0) begin
                  reload_min <= min_clamp;
                  reload_sec <= sec_q;
               end
`endif
            end
            S_RUNNING: begin
               // A pause on the same edge as a tick suppresses the decrement.
               if (!press1 && tick) begin
                  if (sec_q != '0) begin
                     sec_q <= sec_q - 6'd1;
                  end else begin
                     min_q <= min_q - 1'b1;
                     sec_q <= 6'd59;
                  end
               end
            end
`ifdef EGG_TIMER_RELOAD_EN
            S_FINISHED: begin
               if (press0) begin
                  min_q <= reload_min;
                  sec_q <= reload_sec;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign state_o = state;
   assign min_o   = min_q;
   assign sec_o   = sec_q;
   assign done_o  = (state == S_FINISHED);
   assign blink_o = blink;

endmodule

// File: tb/tb_egg_timer_core.sv
// Bench for egg_timer_core with TICK_DIV=4, MAX_MIN=99; expected outputs queued then compared.
module tb_egg_timer_core;

   localparam int TD = 4;
   localparam int MM = 99;
   localparam int MW = $clog2(MM + 1);

   localparam logic [2:0] ST_SS   = 3'b000;
   localparam logic [2:0] ST_SM   = 3'b001;
   localparam logic [2:0] ST_STP  = 3'b010;
   localparam logic [2:0] ST_RUN  = 3'b011;
   localparam logic [2:0] ST_FIN  = 3'b100;
   localparam logic [2:0] ST_IDLE = 3'b101;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    keyin;
   logic [7:0]    setval;
   logic [2:0]    state_o;
   logic [MW-1:0] min_o;
   logic [5:0]    sec_o;
   logic          done_o;
   logic          blink_o;

   egg_timer_core #(.TICK_DIV(TD), .MAX_MIN(MM)) dut (
      .clk     (clk),
      .rst     (rst),
      .keyin   (keyin),
      .setval  (setval),
      .state_o (state_o),
      .min_o   (min_o),
      .sec_o   (sec_o),
      .done_o  (done_o),
      .blink_o (blink_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [2:0] st;
      int         mn;
      int         sc;
      logic       bl;
   } exp_t;

   exp_t       sb[$];
   int         total = 0;
   int         bad   = 0;
   logic [2:0] cur_st;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [2:0] st, input int mn,
                             input int sc, input logic bl);
      exp_t e;
      e.tag = tag; e.st = st; e.mn = mn; e.sc = sc; e.bl = bl;
      sb.push_back(e);
      cur_st = st;
   endtask

   task automatic check_out();
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, ".state"}, 32'(state_o), 32'(e.st));
      chk({e.tag, ".min"},   32'(min_o),   e.mn);
      chk({e.tag, ".sec"},   32'(sec_o),   e.sc);
      chk({e.tag, ".done"},  32'(done_o),  32'(e.st == ST_FIN));
      chk({e.tag, ".blink"}, 32'(blink_o), 32'(e.bl));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Key low for exactly the three edges it takes to reach the state register.
   task automatic press(input int k);
      keyin[k] = 1'b0;
      step(3);
      keyin[k] = 1'b1;
   endtask

   task automatic press_gap(input int k);
      press(k);
      step(3);
   endtask

   task automatic set_time(input int m, input int s);
`ifdef EGG_TIMER_RELOAD_EN
      if (cur_st == ST_FIN) begin
         press_gap(0);
         cur_st = ST_STP;
      end
`endif
      if (cur_st != ST_SS) press_gap(0);
      setval = 8'(s);
      step(3);
      press_gap(0);
      setval = 8'(m);
      press_gap(0);
      expect_out("set_time", ST_STP, m, s, 1'b0);
      check_out();
   endtask

   initial begin
      rst = 1'b1; keyin = 2'b11; setval = 8'd0;
      step(2);
      expect_out("reset", ST_IDLE, 0, 0, 1'b0);
      check_out();
      rst = 1'b0;
      step(2);

      // Held key gives a single event; clamp of seconds field.
      setval = 8'd75;
      keyin[0] = 1'b0;
      step(3);
      expect_out("hold_enter", ST_SS, 0, 0, 1'b0);
      check_out();
      step(97);
      expect_out("hold_100", ST_SS, 0, 59, 1'b0);
      check_out();
      keyin[0] = 1'b1;
      step(3);

      setval = 8'd120;
      press(0);
      expect_out("to_set_min", ST_SM, 0, 59, 1'b0);
      check_out();
      step(1);
      expect_out("min_clamp", ST_SM, 99, 59, 1'b0);
      check_out();
      step(2);
      press(0);
      expect_out("confirm", ST_STP, 99, 59, 1'b0);
      check_out();
      step(3);

      // Countdown, pause colliding with a tick, resume interval.
      set_time(1, 0);
      press(1);
      expect_out("run_start", ST_RUN, 1, 0, 1'b0);
      check_out();
      step(4);
      expect_out("tick1", ST_RUN, 0, 59, 1'b0);
      check_out();
      step(4);
      expect_out("tick2", ST_RUN, 0, 58, 1'b0);
      check_out();
      step(1);
      press(1);
      expect_out("pause_on_tick", ST_STP, 0, 58, 1'b0);
      check_out();
      step(3);
      press(1);
      expect_out("resume", ST_RUN, 0, 58, 1'b0);
      check_out();
      step(3);
      expect_out("resume_3", ST_RUN, 0, 58, 1'b0);
      check_out();
      step(1);
      expect_out("resume_4", ST_RUN, 0, 57, 1'b0);
      check_out();
      press(1);
      expect_out("pause", ST_STP, 0, 57, 1'b0);
      check_out();
      step(3);

      // Run out to FINISHED, blink cadence, key1 ignored.
      set_time(0, 2);
      press(1);
      expect_out("fin_run", ST_RUN, 0, 2, 1'b0);
      check_out();
      step(4);
      expect_out("fin_t1", ST_RUN, 0, 1, 1'b0);
      check_out();
      step(4);
      expect_out("fin_enter", ST_FIN, 0, 0, 1'b0);
      check_out();
      step(3);
      expect_out("blink_pre", ST_FIN, 0, 0, 1'b0);
      check_out();
      step(1);
      expect_out("blink_on", ST_FIN, 0, 0, 1'b1);
      check_out();
      step(4);
      expect_out("blink_off", ST_FIN, 0, 0, 1'b0);
      check_out();
      press(1);
      expect_out("fin_key1", ST_FIN, 0, 0, 1'b0);
      check_out();
      step(3);
      press(0);
`ifdef EGG_TIMER_RELOAD_EN
      expect_out("fin_reload", ST_STP, 0, 2, 1'b0);
`else
      expect_out("fin_key0", ST_SS, 0, 0, 1'b0);
`endif
      check_out();
      step(3);

      // Start at 0:00 goes straight to FINISHED.
      set_time(0, 0);
      press(1);
      expect_out("zero_start", ST_FIN, 0, 0, 1'b0);
      check_out();
      step(3);

      // Asynchronous reset mid-run at 1:30.
      set_time(1, 30);
      press(1);
      expect_out("run_130", ST_RUN, 1, 30, 1'b0);
      check_out();
      step(2);
      #2 rst = 1'b1;
      #1;
      expect_out("async_reset", ST_IDLE, 0, 0, 1'b0);
      check_out();
      #2 rst = 1'b0;
      keyin[0] = 1'b0;
      step(2);
      expect_out("post_rst_2", ST_IDLE, 0, 0, 1'b0);
      check_out();
      step(1);
      expect_out("post_rst_3", ST_SS, 0, 0, 1'b0);
      check_out();
      keyin[0] = 1'b1;
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/egg_timer_core.md
# egg_timer_core

Parametrised successor of the egg-timer controller. Integrates the setup/run/finish state machine with key synchronisation, press-edge detection, a tick prescaler and the minutes:seconds countdown datapath. Display decoders consume `min_o`/`sec_o` and the state code; board keys and switches feed it directly.

## Interface
- `TICK_DIV`, 50_000_000: clock cycles per one-second tick, ≥2.
- `MAX_MIN`, 99: largest settable minutes value, 1..255. `MIN_W = $clog2(MAX_MIN+1)`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `keyin`  in  2  raw board keys, active-low: [0] set/confirm, [1] start/stop.
- `setval`  in  8  switch value for the field being set, unsigned binary.
- `state_o`  out  3  current state code.
- `min_o`  out  MIN_W  minutes count.
- `sec_o`  out  6  seconds count, 0..59.
- `done_o`  out  1  high while FINISHED.
- `blink_o`  out  1  toggles once per tick while FINISHED, else 0.

## Operation
- Each key passes through 2-flop synchroniser plus history flop (`s1`,`s2`,`s3`, reset to 1). Press event = `s3 & ~s2`, one cycle per 1→0 transition. Holding a key yields one event.
- States and codes: SET_SEC 000, SET_MIN 001, STOPPED 010, RUNNING 011, FINISHED 100, IDLE 101 (reset state).
- IDLE: press0 → SET_SEC.
- SET_SEC: `sec_o` loads `min(setval,59)` every cycle. press0 → SET_MIN.
- SET_MIN: `min_o` loads `min(setval,MAX_MIN)` every cycle. press0 → STOPPED; the current min:sec is latched into the reload register.
- STOPPED: press1 → RUNNING, or → FINISHED if count is 0:00. press0 → SET_SEC.
- RUNNING: on each tick, decrement. If `sec_o>0`, `sec_o-1`; otherwise `min_o-1` and `sec_o=59`. A tick at 0:01 writes 0:00 and enters FINISHED on the same edge. press1 → STOPPED, count held.
- FINISHED: `done_o=1`; `blink_o` toggles on each tick. press0 → SET_SEC with `blink_o` cleared. press1 is ignored.
- Prescaler counts 0..TICK_DIV-1 in RUNNING and FINISHED. Tick is asserted when count = TICK_DIV-1; the count then wraps to 0. The prescaler clears to 0 on any state change and in every other state.
- Simultaneous events:
  - press1 has priority over press0 in STOPPED and RUNNING; press0 is dropped.
  - In RUNNING, press1 coinciding with a tick: the pause wins and no decrement occurs.
- Unused codes 110/111 → IDLE on the next edge.

## Timing
- Reset values: `state_o`=101, `min_o`=0, `sec_o`=0, `done_o`=0, `blink_o`=0. Reset mid-run discards count and reload register immediately (asynchronous).
- Key latency: the key is low before edge 1, `s1` samples at edge 1, `s2` at edge 2, and the state updates at edge 3.
- First decrement occurs TICK_DIV cycles after entering RUNNING; subsequent decrements follow every TICK_DIV cycles. Resuming after a pause restarts the full TICK_DIV interval.
- In SET states, `setval` changes appear on the outputs one edge later.
- All outputs are registered; there is no combinational path from inputs.

## Configuration
- `EGG_TIMER_RELOAD_EN` defined: in FINISHED, press0 → STOPPED with min:sec reloaded from the reload register, enabling repeat runs without re-entry. The path to SET_SEC is then via press0 from STOPPED.
- Undefined: no reload register is built; FINISHED press0 → SET_SEC and the count stays 0:00 until it is set.

## Test plan
- Reset mid-RUNNING at 1:30 → all outputs equal the reset values within the same cycle. Release, press0 → SET_SEC after 3 edges.
- Set `setval`=75 in SET_SEC, 120 in SET_MIN with MAX_MIN=99 → `sec_o`=59, `min_o`=99 after confirm.
- TICK_DIV=4, count 1:00, press1 → 0:59 after 4 cycles, then 0:58 after 4 more. Press1 again → STOPPED at the current value. A tick coinciding with the press does not decrement.
- Count 0:02 RUNNING, TICK_DIV=4 → FINISHED with 0:00 on the second tick. `done_o`=1, `blink_o` toggles every 4 cycles, press1 has no effect.
- STOPPED at 0:00, press1 → FINISHED directly. Hold key0 low 100 cycles in IDLE → exactly one transition to SET_SEC.
- With `EGG_TIMER_RELOAD_EN`, set 0:03, run to FINISHED, press0 → STOPPED at 0:03. Without the macro, the same press → SET_SEC.
